sisc_ctrl_hs: RTL and testbench
===============================

// Module: sisc_ctrl_hs
// PURPOSE
//  Next-gen SISC multi-cycle control FSM. Sequences fetch/decode/execute/mem/writeback with
//  req/ack handshakes to instruction and data memory, so memories may insert wait states.
//  Adds a bus timeout, a sticky HALT state in place of simulation $stop, and a FAULT state
//  for illegal opcodes. Sits between the IR/status register and the datapath muxes, ALU,
//  PC and RF.
// PARAMETERS
//  OPC_W    4   opcode field width
//  MM_W     4   mode/condition-mask field width; also the stat width
//  TIMEOUT  15  max wait cycles on im_ack/dm_ack before FAULT; 0 = no timeout
//  CNT_W    32  perf counter width (SISC_PERF_EN only)
// PORTS
//  clk      in   1      clock, rising edge
//  rst_f    in   1      asynchronous, active-high reset
//  opcode   in   OPC_W  IR opcode field
//  mm       in   MM_W   IR mode / condition mask
//  stat     in   MM_W   status flags
//  im_ack   in   1      instruction memory ack; IR data valid this cycle
//  dm_ack   in   1      data memory ack; read data valid / write accepted this cycle
//  im_req   out  1      instruction fetch request
//  dm_req   out  1      data memory request
//  dm_we    out  1      data memory write enable, qualified by dm_req
//  ir_load  out  1      load IR
//  pc_write out  1      PC write enable
//  pc_sel   out  1      0 = PC+1, 1 = branch target
//  br_sel   out  1      1 = absolute target, 0 = PC-relative
//  pc_rst   out  1      PC reset
//  rb_sel   out  1      RF read-port-B select (1 = rd field, for STR)
//  alu_op   out  2      00 reg, 01 imm, 10 addr reg, 11 addr imm
//  wb_sel   out  2      0 = ALU, 1 = memory
//  rf_we    out  1      register file write enable
//  halted   out  1      HLT executed; sticky until reset
//  fault    out  1      illegal opcode or timeout; sticky until reset
//  cyc_cnt  out  CNT_W  cycles since reset (SISC_PERF_EN only)
//  ins_cnt  out  CNT_W  instructions retired (SISC_PERF_EN only)
// BEHAVIOUR
//  - State register is async-reset to START. Outputs are combinational from state, opcode,
//    mm, stat and the acks. No latches; every output has a default of 0.
//  - START: pc_rst=1, all other outputs 0 (these are the reset values). Next state FETCH.
//  - FETCH: im_req=1. On im_ack: ir_load=1, pc_write=1, pc_sel=0, then DECODE. Otherwise stay.
//  - DECODE: opcodes NOOP=0 LOD=1 STR=2 BRA=4 BRR=5 BNE=6 BNR=7 ALU=8 HLT=15.
//    - taken = |(stat&mm) for BRA/BRR; ~|(stat&mm) for BNE/BNR.
//    - If taken: pc_write=1, pc_sel=1; br_sel=1 for BRA/BNE, 0 for BRR/BNR.
//    - Branch or NOOP -> FETCH. HLT -> HALT. Opcodes 3 and 9..14 -> FAULT.
//    - STR: rb_sel=1. Otherwise -> EXECUTE.
//  - EXECUTE: alu_op = ALU ? (mm==8 ? 01 : 00) : (mm==8 ? 11 : 10); STR holds rb_sel=1.
//    ALU -> WB; LOD/STR -> MEM.
//  - MEM: dm_req=1; dm_we=1 for STR; outputs held until dm_ack. On ack: STR -> FETCH,
//    LOD -> WB.
//  - WB: rf_we=1 for exactly one cycle; wb_sel = (LOD ? 1 : 0). Next state FETCH.
//  - HALT: halted=1, all requests 0; leaves only on reset. FAULT: same, with fault=1.
//  - Wait counter: clears on entry to FETCH/MEM and increments each un-acked wait cycle.
//    Reaching TIMEOUT un-acked -> FAULT, with req dropped in that cycle.
//    An ack in the same cycle as expiry wins (no fault).
//  - Reset mid-handshake drops im_req/dm_req asynchronously. No partial writeback.
//  - Min latency (ack same cycle as req): ALU 4 clk, LOD 5, STR 4, branch/NOOP 2.
// CONFIGURATION
//  `SISC_PERF_EN defined:
//    - cyc_cnt increments every cycle outside START/HALT/FAULT.
//    - ins_cnt increments on each retire (WB exit, STR MEM ack, branch/NOOP DECODE exit).
//    - Both wrap modulo 2^CNT_W and reset to 0.
//  Undefined: both ports are tied to 0 and no counter flops exist.
// STRUCTURE
//  - sisc_ctrl_pkg holds state enum localparams (START..FAULT), opcode localparams,
//    AM_IMM=8, and the alu_op/wb_sel codes; datapath blocks share it.
//  - One sub-module, sisc_br_eval: comb (opcode, mm, stat) -> taken, br_abs.
// TESTING
//  1. rst_f 1->0: one START cycle with pc_rst=1, then im_req=1 in the next cycle;
//     every other output 0.
//  2. ALU mm=8, acks immediate: alu_op=01 in EXECUTE; rf_we=1, wb_sel=0 one cycle;
//     4 clk total.
//  3. LOD mm=0 with dm_ack delayed 3 clk: dm_req held 4 cycles, dm_we=0; then WB with
//     wb_sel=1, rf_we=1.
//  4. BNE stat=0100, mm=0100: not taken, pc_write=0 in DECODE. With mm=0010: pc_sel=1,
//     br_sel=1, pc_write=1.
//  5. TIMEOUT=3, im_ack never: fault=1 after 3 wait cycles, im_req=0. Ack on the 3rd
//     cycle: no fault.
//  6. opcode 15 -> halted=1 sticky. opcode 12 -> fault=1. rst_f asserted mid-MEM:
//     dm_req drops at once; START after release.

Source files
------------

// File: rtl/sisc_ctrl_pkg.sv
// Shared SISC control encodings: FSM states, opcodes, addressing mode and mux codes.
package sisc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  localparam int AM_IMM = 8;

  localparam logic [1:0] ALU_REG  = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_AREG = 2'b10;
  localparam logic [1:0] ALU_AIMM = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;

endpackage

// File: rtl/sisc_br_eval.sv
// Branch condition evaluation: taken flag and absolute/relative target select.
module sisc_br_eval
  import sisc_ctrl_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int MM_W  = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  output logic             taken,
  output logic             br_abs
);

  logic hit, is_pos, is_neg;

  assign hit    = |(stat & mm);
  assign is_pos = (opcode == OPC_W'(OP_BRA)) || (opcode == OPC_W'(OP_BRR));
  assign is_neg = (opcode == OPC_W'(OP_BNE)) || (opcode == OPC_W'(OP_BNR));
  assign taken  = (is_pos & hit) | (is_neg & ~hit);
  assign br_abs = (opcode == OPC_W'(OP_BRA)) || (opcode == OPC_W'(OP_BNE));

endmodule

// File: rtl/sisc_ctrl_hs.sv
// SISC multi-cycle control FSM with req/ack memory handshakes, bus timeout, HALT and FAULT.
// Optional perf counters (cyc_cnt/ins_cnt) are built when SISC_PERF_EN is defined.
module sisc_ctrl_hs
  import sisc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int MM_W    = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_load,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             pc_rst,
  output logic             rb_sel,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             rf_we,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ins_cnt
);

  localparam int WT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t          state, nxt;
  logic [WT_W-1:0] wait_cnt;
  logic            taken, br_abs;
  logic            is_lod, is_str, is_alu, is_br, is_noop, is_hlt, is_imm;
  logic            waiting, expire;

  sisc_br_eval #(.OPC_W(OPC_W), .MM_W(MM_W)) u_br (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (taken),
    .br_abs (br_abs)
  );

  assign is_lod  = (opcode == OPC_W'(OP_LOD));
  assign is_str  = (opcode == OPC_W'(OP_STR));
  assign is_alu  = (opcode == OPC_W'(OP_ALU));
  assign is_noop = (opcode == OPC_W'(OP_NOOP));
  assign is_hlt  = (opcode == OPC_W'(OP_HLT));
  assign is_br   = (opcode >= OPC_W'(OP_BRA)) && (opcode <= OPC_W'(OP_BNR));
  assign is_imm  = (mm == MM_W'(AM_IMM));

  // Expiry is the TIMEOUT-th un-acked wait cycle; an ack in that cycle still proceeds.
  assign waiting = ((state == S_FETCH) && !im_ack) || ((state == S_MEM) && !dm_ack);
  assign expire  = (TIMEOUT != 0) && waiting && (wait_cnt == WT_W'(TIMEOUT - 1));

  always_comb begin
    nxt      = state;
    im_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = ALU_REG;
    wb_sel   = WB_ALU;
    rf_we    = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (state)
      S_START: begin
        pc_rst = 1'b1;
        nxt    = S_FETCH;
      end
      S_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (expire) begin
          nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        if (is_br) begin
          pc_write = taken;
          pc_sel   = taken;
          br_sel   = taken & br_abs;
          nxt      = S_FETCH;
        end else if (is_noop) begin
          nxt = S_FETCH;
        end else if (is_hlt) begin
          nxt = S_HALT;
        end else if (is_lod || is_str || is_alu) begin
          rb_sel = is_str;
          nxt    = S_EXECUTE;
        end else begin
          nxt = S_FAULT;
        end
      end
      S_EXECUTE: begin
        alu_op = is_alu ? (is_imm ? ALU_IMM : ALU_REG) : (is_imm ? ALU_AIMM : ALU_AREG);
        rb_sel = is_str;
        nxt    = is_alu ? S_WB : S_MEM;
      end
      S_MEM: begin
        // Store data on read port B stays selected for the whole write handshake.
        dm_req = 1'b1;
        dm_we  = is_str;
        rb_sel = is_str;
        if (dm_ack)      nxt = is_str ? S_FETCH : S_WB;
        else if (expire) nxt = S_FAULT;
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = is_lod ? WB_MEM : WB_ALU;
        nxt    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state    <= S_START;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= (waiting && (nxt == state)) ? wait_cnt + 1'b1 : '0;
    end
  end

`ifdef SISC_PERF_EN
  logic             retire, active;
  logic [CNT_W-1:0] cyc_q, ins_q;

  assign active = (state != S_START) && (state != S_HALT) && (state != S_FAULT);
  assign retire = (state == S_WB) ||
                  ((state == S_MEM) && dm_ack && is_str) ||
                  ((state == S_DECODE) && (is_br || is_noop));

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (active) cyc_q <= cyc_q + 1'b1;
      if (retire) ins_q <= ins_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = '0;
  assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_sisc_ctrl_hs.sv
// Directed bench for sisc_ctrl_hs: main instance (default TIMEOUT) plus a TIMEOUT=3 instance.
module tb_sisc_ctrl_hs;

  localparam logic [15:0] FAULT_B = 16'h0001;
  localparam logic [15:0] HALT_B  = 16'h0002;
  localparam logic [15:0] RFWE    = 16'h0004;
  localparam logic [15:0] WBMEM   = 16'h0008;
  localparam logic [15:0] A_IMM   = 16'h0020;
  localparam logic [15:0] A_AREG  = 16'h0040;
  localparam logic [15:0] A_AIMM  = 16'h0060;
  localparam logic [15:0] RBSEL   = 16'h0080;
  localparam logic [15:0] PCRST   = 16'h0100;
  localparam logic [15:0] BRSEL   = 16'h0200;
  localparam logic [15:0] PCSEL   = 16'h0400;
  localparam logic [15:0] PCW     = 16'h0800;
  localparam logic [15:0] IRLD    = 16'h1000;
  localparam logic [15:0] DMWE    = 16'h2000;
  localparam logic [15:0] DMREQ   = 16'h4000;
  localparam logic [15:0] IMREQ   = 16'h8000;
  localparam logic [15:0] FA      = IMREQ | IRLD | PCW;

  logic clk = 1'b0;
  logic rst_f, rst_t;
  logic [3:0] opcode, mm, stat;
  logic im_ack, dm_ack, im_ack_t;
  logic dm_ack_t;

  logic im_req, dm_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst, rb_sel, rf_we, halted, fault;
  logic [1:0] alu_op, wb_sel;
  logic [31:0] cyc_cnt, ins_cnt;

  logic im_req_t, dm_req_t, dm_we_t, ir_load_t, pc_write_t, pc_sel_t, br_sel_t, pc_rst_t;
  logic rb_sel_t, rf_we_t, halted_t, fault_t;
  logic [1:0] alu_op_t, wb_sel_t;
  logic [31:0] cyc_cnt_t, ins_cnt_t;

  logic [15:0] outs, outs_t;
  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sisc_ctrl_hs dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .im_ack(im_ack), .dm_ack(dm_ack), .im_req(im_req), .dm_req(dm_req), .dm_we(dm_we),
    .ir_load(ir_load), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel), .pc_rst(pc_rst),
    .rb_sel(rb_sel), .alu_op(alu_op), .wb_sel(wb_sel), .rf_we(rf_we), .halted(halted),
    .fault(fault), .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
  );

  sisc_ctrl_hs #(.TIMEOUT(3)) dut_to (
    .clk(clk), .rst_f(rst_t), .opcode(opcode), .mm(mm), .stat(stat),
    .im_ack(im_ack_t), .dm_ack(dm_ack_t), .im_req(im_req_t), .dm_req(dm_req_t), .dm_we(dm_we_t),
    .ir_load(ir_load_t), .pc_write(pc_write_t), .pc_sel(pc_sel_t), .br_sel(br_sel_t),
    .pc_rst(pc_rst_t), .rb_sel(rb_sel_t), .alu_op(alu_op_t), .wb_sel(wb_sel_t), .rf_we(rf_we_t),
    .halted(halted_t), .fault(fault_t), .cyc_cnt(cyc_cnt_t), .ins_cnt(ins_cnt_t)
  );

  assign outs   = {im_req, dm_req, dm_we, ir_load, pc_write, pc_sel, br_sel, pc_rst,
                   rb_sel, alu_op, wb_sel, rf_we, halted, fault};
  assign outs_t = {im_req_t, dm_req_t, dm_we_t, ir_load_t, pc_write_t, pc_sel_t, br_sel_t, pc_rst_t,
                   rb_sel_t, alu_op_t, wb_sel_t, rf_we_t, halted_t, fault_t};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ck(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, outs}, {16'h0, exp});
  endtask

  task automatic ck_t(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, outs_t}, {16'h0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_f = 1'b1; rst_t = 1'b1; opcode = '0; mm = '0; stat = '0;
    im_ack = 1'b0; dm_ack = 1'b0; im_ack_t = 1'b0; dm_ack_t = 1'b0;
    cyc(); cyc();
    ck("rst_hold", PCRST);
    rst_f = 1'b0; #1 ck("start", PCRST);
    cyc(); #1 ck("fetch_idle", IMREQ);

    // ALU immediate
    im_ack = 1'b1; opcode = 4'd8; mm = 4'd8; #1 ck("alu_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("alu_dec", 16'h0);
    cyc(); #1 ck("alu_exe", A_IMM);
    cyc(); #1 ck("alu_wb", RFWE);
    cyc(); #1 ck("alu_next", IMREQ);

    // LOD with dm_ack on the 4th MEM cycle
    im_ack = 1'b1; opcode = 4'd1; mm = 4'd0; #1 ck("lod_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("lod_dec", 16'h0);
    cyc(); #1 ck("lod_exe", A_AREG);
    cyc(); #1 ck("lod_mem1", DMREQ);
    cyc(); #1 ck("lod_mem2", DMREQ);
    cyc(); #1 ck("lod_mem3", DMREQ);
    cyc(); dm_ack = 1'b1; #1 ck("lod_mem4", DMREQ);
    cyc(); dm_ack = 1'b0; #1 ck("lod_wb", WBMEM | RFWE);
    cyc(); #1 ck("lod_next", IMREQ);

    // STR address-immediate, immediate ack
    im_ack = 1'b1; opcode = 4'd2; mm = 4'd8; #1 ck("str_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("str_dec", RBSEL);
    cyc(); #1 ck("str_exe", RBSEL | A_AIMM);
    cyc(); dm_ack = 1'b1; #1 ck("str_mem", DMREQ | DMWE | RBSEL);
    cyc(); dm_ack = 1'b0; #1 ck("str_next", IMREQ);

    // BNE not taken, BNE taken, BRR taken
    im_ack = 1'b1; opcode = 4'd6; mm = 4'b0100; stat = 4'b0100; #1 ck("bne_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("bne_nt", 16'h0);
    cyc(); #1 ck("bne_nt_next", IMREQ);
    im_ack = 1'b1; mm = 4'b0010; #1 ck("bne2_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("bne_t", PCW | PCSEL | BRSEL);
    cyc(); #1 ck("bne_t_next", IMREQ);
    im_ack = 1'b1; opcode = 4'd5; mm = 4'b0100; #1 ck("brr_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("brr_t", PCW | PCSEL);
    cyc(); #1 ck("brr_next", IMREQ);

`ifdef SISC_PERF_EN
    chk("ins_cnt", ins_cnt, 32'd6);
`else
    chk("ins_cnt_tied", ins_cnt, 32'd0);
    chk("cyc_cnt_tied", cyc_cnt, 32'd0);
`endif

    // HLT is sticky
    im_ack = 1'b1; opcode = 4'd15; #1 ck("hlt_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("hlt_dec", 16'h0);
    cyc(); #1 ck("halt", HALT_B);
    cyc(); im_ack = 1'b1; dm_ack = 1'b1; #1 ck("halt_sticky", HALT_B);
    im_ack = 1'b0; dm_ack = 1'b0;

    // Illegal opcode -> sticky FAULT
    rst_f = 1'b1; cyc(); rst_f = 1'b0; #1 ck("start2", PCRST);
    cyc(); im_ack = 1'b1; opcode = 4'd12; #1 ck("ill_fetch", FA);
    cyc(); im_ack = 1'b0; #1 ck("ill_dec", 16'h0);
    cyc(); #1 ck("fault", FAULT_B);
    cyc(); #1 ck("fault_sticky", FAULT_B);

    // Reset asserted mid-MEM drops dm_req immediately
    rst_f = 1'b1; cyc(); rst_f = 1'b0; #1;
    cyc(); im_ack = 1'b1; opcode = 4'd1; mm = 4'd0; #1;
    cyc(); im_ack = 1'b0; #1;
    cyc(); #1;
    cyc(); #1 ck("mem_pre_rst", DMREQ);
    #1 rst_f = 1'b1; #1 ck("rst_mid_mem", PCRST);
    cyc(); rst_f = 1'b0; #1 ck("start3", PCRST);
    cyc(); #1 ck("fetch3", IMREQ);
    rst_f = 1'b1;

    // TIMEOUT=3 instance: no ack -> FAULT after 3 wait cycles
    opcode = 4'd0;
    cyc(); rst_t = 1'b0; #1 ck_t("to_start", PCRST);
    cyc(); #1 ck_t("to_w1", IMREQ);
    cyc(); #1 ck_t("to_w2", IMREQ);
    cyc(); #1 ck_t("to_w3", IMREQ);
    cyc(); #1 ck_t("to_fault", FAULT_B);
    cyc(); im_ack_t = 1'b1; #1 ck_t("to_sticky", FAULT_B);
    im_ack_t = 1'b0;

    // Ack on the 3rd wait cycle wins over expiry
    rst_t = 1'b1; cyc(); rst_t = 1'b0; #1 ck_t("to_start2", PCRST);
    cyc(); #1 ck_t("to_a1", IMREQ);
    cyc(); #1 ck_t("to_a2", IMREQ);
    cyc(); im_ack_t = 1'b1; #1 ck_t("to_a3_ack", FA);
    cyc(); im_ack_t = 1'b0; #1 ck_t("to_noop_dec", 16'h0);
    cyc(); #1 ck_t("to_refetch", IMREQ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
